// File: rtl/scan_chain_ctrl_pkg.sv
// scan_chain_ctrl_pkg: shared FSM state encoding and default chain length
// for the scan chain controller and its shift register.
package scan_chain_ctrl_pkg;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        CAPTURE = 2'd1,
        SHIFT   = 2'd2,
        DONE    = 2'd3
    } state_e;

    localparam int DefaultChainLen = 8;

endpackage

// File: rtl/scan_chain_ctrl_shift_reg.sv
// scan_shift_reg: transmit/receive shift registers and shift counter; flags
// the final shift so the controller can leave SHIFT after ChainLen edges.
module scan_shift_reg
    import scan_chain_ctrl_pkg::*;
#(
    parameter int ChainLen = DefaultChainLen,
    parameter int CntWidth = $clog2(ChainLen + 1)
) (
    input  logic                clk_i,
    input  logic                rst_ni,
    input  logic                load_i,
    input  logic [ChainLen-1:0] data_i,
    input  logic                shift_i,
    input  logic                scan_q_i,
    output logic                tx_msb_o,
    output logic [ChainLen-1:0] rx_o,
    output logic                last_o
);

    logic [ChainLen-1:0] tx;
    logic [CntWidth-1:0] cnt;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            tx   <= '0;
            rx_o <= '0;
            cnt  <= '0;
        end else if (load_i) begin
            tx   <= data_i;
            rx_o <= '0;
            cnt  <= '0;
        end else if (shift_i) begin
            tx   <= {tx[ChainLen-2:0], 1'b0};
            rx_o <= {rx_o[ChainLen-2:0], scan_q_i};
            cnt  <= cnt + CntWidth'(1);
        end
    end

    assign tx_msb_o = tx[ChainLen-1];
    // The edge taken while cnt == ChainLen-1 is the ChainLen-th shift.
    assign last_o   = (cnt == CntWidth'(ChainLen - 1));

endmodule

// File: rtl/scan_chain_ctrl.sv
// scan_chain_ctrl: loads a parallel word into a scan chain MSB first and returns
// the previous chain contents. Optional rsp_parity_o via SCAN_CHAIN_CTRL_PARITY_EN.
module scan_chain_ctrl
    import scan_chain_ctrl_pkg::*;
#(
    parameter int ChainLen = DefaultChainLen
) (
    input  logic                clk_i,
    input  logic                rst_ni,
    input  logic                req_valid_i,
    output logic                req_ready_o,
    input  logic [ChainLen-1:0] req_data_i,
    input  logic                req_capture_i,
    output logic                rsp_valid_o,
    input  logic                rsp_ready_i,
    output logic [ChainLen-1:0] rsp_data_o,
    output logic                scan_en_o,
    output logic                scan_d_o,
    input  logic                scan_q_i,
    output logic                dis_o,
`ifdef SCAN_CHAIN_CTRL_PARITY_EN
    output logic                rsp_parity_o,
`endif
    output logic                busy_o
);

    localparam int CntWidth = $clog2(ChainLen + 1);

    state_e              state;
    logic                load;
    logic                shift;
    logic                last;
    logic                tx_msb;
    logic [ChainLen-1:0] rx;

    assign load  = (state == IDLE) && req_valid_i;
    assign shift = (state == SHIFT);

    scan_shift_reg #(
        .ChainLen (ChainLen),
        .CntWidth (CntWidth)
    ) u_shift (
        .clk_i    (clk_i),
        .rst_ni   (rst_ni),
        .load_i   (load),
        .data_i   (req_data_i),
        .shift_i  (shift),
        .scan_q_i (scan_q_i),
        .tx_msb_o (tx_msb),
        .rx_o     (rx),
        .last_o   (last)
    );

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state       <= IDLE;
            req_ready_o <= 1'b1;
            rsp_valid_o <= 1'b0;
            scan_en_o   <= 1'b0;
            dis_o       <= 1'b1;
            busy_o      <= 1'b0;
        end else begin
            case (state)
                IDLE: if (req_valid_i) begin
                    state       <= req_capture_i ? CAPTURE : SHIFT;
                    req_ready_o <= 1'b0;
                    busy_o      <= 1'b1;
                    scan_en_o   <= ~req_capture_i;
                    dis_o       <= ~req_capture_i;
                end
                CAPTURE: begin
                    state     <= SHIFT;
                    scan_en_o <= 1'b1;
                    dis_o     <= 1'b1;
                end
                SHIFT: if (last) begin
                    state       <= DONE;
                    scan_en_o   <= 1'b0;
                    rsp_valid_o <= 1'b1;
                end
                default: if (rsp_ready_i) begin
                    state       <= IDLE;
                    rsp_valid_o <= 1'b0;
                    req_ready_o <= 1'b1;
                    busy_o      <= 1'b0;
                end
            endcase
        end
    end

    // Gate so the chain sees a quiet scan input outside SHIFT.
    assign scan_d_o   = scan_en_o & tx_msb;
    assign rsp_data_o = rx;

`ifdef SCAN_CHAIN_CTRL_PARITY_EN
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) rsp_parity_o <= 1'b0;
        else if (shift && last) rsp_parity_o <= ^{rx[ChainLen-2:0], scan_q_i};
    end
`endif

endmodule

// File: tb/tb_scan_chain_ctrl.sv
// tb_scan_chain_ctrl: directed bench driving scan_chain_ctrl against a model of
// eight hold-enable scan flops; prints CHECKS/ERRORS summary.
module tb_scan_chain_ctrl;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       req_valid, req_ready, req_capture;
    logic [7:0] req_data;
    logic       rsp_valid, rsp_ready;
    logic [7:0] rsp_data;
    logic       scan_en, scan_d, scan_q, dis, busy;
`ifdef SCAN_CHAIN_CTRL_PARITY_EN
    logic       rsp_parity;
`endif

    logic [7:0] chain, func_d, pre_val;
    logic       pre_en;
    int         checks = 0;
    int         errors = 0;

    always #5 clk = ~clk;

    scan_chain_ctrl #(.ChainLen(8)) dut (
        .clk_i         (clk),
        .rst_ni        (rst_n),
        .req_valid_i   (req_valid),
        .req_ready_o   (req_ready),
        .req_data_i    (req_data),
        .req_capture_i (req_capture),
        .rsp_valid_o   (rsp_valid),
        .rsp_ready_i   (rsp_ready),
        .rsp_data_o    (rsp_data),
        .scan_en_o     (scan_en),
        .scan_d_o      (scan_d),
        .scan_q_i      (scan_q),
        .dis_o         (dis),
`ifdef SCAN_CHAIN_CTRL_PARITY_EN
        .rsp_parity_o  (rsp_parity),
`endif
        .busy_o        (busy)
    );

    // Flop chain model: scan shifts, otherwise dis low loads functional d, dis high holds.
    always_ff @(posedge clk) begin
        if (pre_en) chain <= pre_val;
        else if (scan_en) chain <= {chain[6:0], scan_d};
        else if (!dis) chain <= func_d;
    end
    assign scan_q = chain[7];

    task automatic preload(input logic [7:0] v);
        @(negedge clk);
        pre_val = v;
        pre_en  = 1'b1;
        @(posedge clk);
        #1 pre_en = 1'b0;
    endtask

    task automatic do_txn(input logic [7:0] d, input logic cap,
                          output int en_cnt, output int dis_cnt, output int vcyc);
        @(negedge clk);
        req_valid   = 1'b1;
        req_data    = d;
        req_capture = cap;
        @(posedge clk);
        #1 req_valid = 1'b0;
        en_cnt  = 0;
        dis_cnt = 0;
        vcyc    = 0;
        for (int i = 1; i <= 20 && vcyc == 0; i++) begin
            @(negedge clk);
            if (scan_en) en_cnt++;
            if (!dis) dis_cnt++;
            if (rsp_valid) vcyc = i;
        end
    endtask

    task automatic ack();
        @(negedge clk);
        rsp_ready = 1'b1;
        @(posedge clk);
        #1 rsp_ready = 1'b0;
    endtask

    task automatic test_reset();
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        repeat (3) @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        checks++; if (req_ready !== 1'b1) begin errors++; $display("FAIL reset_req_ready got %b exp 1", req_ready); end
        checks++; if (scan_en !== 1'b0) begin errors++; $display("FAIL reset_scan_en got %b exp 0", scan_en); end
        checks++; if (dis !== 1'b1) begin errors++; $display("FAIL reset_dis got %b exp 1", dis); end
        checks++; if (rsp_valid !== 1'b0) begin errors++; $display("FAIL reset_rsp_valid got %b exp 0", rsp_valid); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy got %b exp 0", busy); end
        checks++; if (rsp_data !== 8'h00) begin errors++; $display("FAIL reset_rsp_data got %h exp 00", rsp_data); end
        checks++; if (scan_d !== 1'b0) begin errors++; $display("FAIL reset_scan_d got %b exp 0", scan_d); end
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic test_shift();
        int en, dl, vc;
        preload(8'h3C);
        do_txn(8'hA5, 1'b0, en, dl, vc);
        checks++; if (en !== 8) begin errors++; $display("FAIL shift_en_cycles got %0d exp 8", en); end
        checks++; if (dl !== 0) begin errors++; $display("FAIL shift_dis_low got %0d exp 0", dl); end
        checks++; if (vc !== 9) begin errors++; $display("FAIL shift_rsp_cycle got %0d exp 9", vc); end
        checks++; if (rsp_data !== 8'h3C) begin errors++; $display("FAIL shift_rsp_data got %h exp 3c", rsp_data); end
        checks++; if (chain !== 8'hA5) begin errors++; $display("FAIL shift_chain got %h exp a5", chain); end
        ack();
        @(negedge clk);
        checks++; if (req_ready !== 1'b1 || rsp_valid !== 1'b0 || busy !== 1'b0) begin
            errors++; $display("FAIL shift_idle got rdy=%b vld=%b busy=%b exp 1 0 0", req_ready, rsp_valid, busy);
        end
    endtask

    task automatic test_capture();
        int en, dl, vc;
        preload(8'hFF);
        func_d = 8'h5A;
        do_txn(8'h00, 1'b1, en, dl, vc);
        checks++; if (dl !== 1) begin errors++; $display("FAIL cap_dis_low got %0d exp 1", dl); end
        checks++; if (en !== 8) begin errors++; $display("FAIL cap_en_cycles got %0d exp 8", en); end
        checks++; if (vc !== 10) begin errors++; $display("FAIL cap_rsp_cycle got %0d exp 10", vc); end
        checks++; if (rsp_data !== 8'h5A) begin errors++; $display("FAIL cap_rsp_data got %h exp 5a", rsp_data); end
        checks++; if (chain !== 8'h00) begin errors++; $display("FAIL cap_chain got %h exp 00", chain); end
        ack();
    endtask

    task automatic test_backpressure();
        int en, dl, vc;
        bit seen;
        preload(8'h81);
        do_txn(8'hC3, 1'b0, en, dl, vc);
        checks++; if (vc !== 9) begin errors++; $display("FAIL bp_rsp_cycle got %0d exp 9", vc); end
        req_valid = 1'b1;
        req_data  = 8'hFF;
        req_capture = 1'b0;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            checks++; if (rsp_valid !== 1'b1 || rsp_data !== 8'h81) begin
                errors++; $display("FAIL bp_rsp_hold cyc %0d got vld=%b data=%h exp 1 81", i, rsp_valid, rsp_data);
            end
            checks++; if (req_ready !== 1'b0 || scan_en !== 1'b0 || dis !== 1'b1) begin
                errors++; $display("FAIL bp_ctrl cyc %0d got rdy=%b en=%b dis=%b exp 0 0 1", i, req_ready, scan_en, dis);
            end
            checks++; if (chain !== 8'hC3) begin errors++; $display("FAIL bp_chain cyc %0d got %h exp c3", i, chain); end
        end
        rsp_ready = 1'b1;
        @(posedge clk);
        #1 rsp_ready = 1'b0;
        @(negedge clk);
        checks++; if (req_ready !== 1'b1 || busy !== 1'b0) begin
            errors++; $display("FAIL bp_idle got rdy=%b busy=%b exp 1 0", req_ready, busy);
        end
        @(posedge clk);
        #1 req_valid = 1'b0;
        @(negedge clk);
        checks++; if (scan_en !== 1'b1 || busy !== 1'b1) begin
            errors++; $display("FAIL bp_next_accept got en=%b busy=%b exp 1 1", scan_en, busy);
        end
        seen = 0;
        for (int i = 0; i < 12 && !seen; i++) begin
            @(negedge clk);
            if (rsp_valid) seen = 1;
        end
        checks++; if (!seen) begin errors++; $display("FAIL bp_next_timeout got no rsp_valid exp rsp_valid"); end
        checks++; if (rsp_data !== 8'hC3 || chain !== 8'hFF) begin
            errors++; $display("FAIL bp_next_data got rsp=%h chain=%h exp c3 ff", rsp_data, chain);
        end
        ack();
    endtask

    task automatic test_reset_mid_shift();
        int en, dl, vc;
        bit vld_seen;
        preload(8'h0F);
        @(negedge clk);
        req_valid   = 1'b1;
        req_data    = 8'hF0;
        req_capture = 1'b0;
        @(posedge clk);
        #1 req_valid = 1'b0;
        repeat (3) @(posedge clk);
        #2 rst_n = 1'b0;
        #1;
        checks++; if (scan_en !== 1'b0) begin errors++; $display("FAIL rst_mid_scan_en got %b exp 0", scan_en); end
        checks++; if (busy !== 1'b0 || req_ready !== 1'b1) begin
            errors++; $display("FAIL rst_mid_state got busy=%b rdy=%b exp 0 1", busy, req_ready);
        end
        checks++; if (chain !== 8'h7F) begin errors++; $display("FAIL rst_mid_chain got %h exp 7f", chain); end
        @(negedge clk);
        rst_n = 1'b1;
        vld_seen = 0;
        repeat (4) begin
            @(negedge clk);
            if (rsp_valid) vld_seen = 1;
        end
        checks++; if (vld_seen) begin errors++; $display("FAIL rst_mid_no_rsp got rsp_valid exp none"); end
        do_txn(8'h66, 1'b0, en, dl, vc);
        checks++; if (vc !== 9 || en !== 8) begin errors++; $display("FAIL rst_mid_next got vc=%0d en=%0d exp 9 8", vc, en); end
        checks++; if (rsp_data !== 8'h7F || chain !== 8'h66) begin
            errors++; $display("FAIL rst_mid_next_data got rsp=%h chain=%h exp 7f 66", rsp_data, chain);
        end
        ack();
    endtask

`ifdef SCAN_CHAIN_CTRL_PARITY_EN
    task automatic test_parity();
        int en, dl, vc;
        preload(8'hA5);
        do_txn(8'h01, 1'b0, en, dl, vc);
        checks++; if (rsp_data !== 8'hA5 || rsp_parity !== 1'b0) begin
            errors++; $display("FAIL parity_a5 got rsp=%h par=%b exp a5 0", rsp_data, rsp_parity);
        end
        ack();
        do_txn(8'h00, 1'b0, en, dl, vc);
        checks++; if (rsp_data !== 8'h01 || rsp_parity !== 1'b1) begin
            errors++; $display("FAIL parity_01 got rsp=%h par=%b exp 01 1", rsp_data, rsp_parity);
        end
        ack();
    endtask
`endif

    initial begin
        rst_n       = 1'b0;
        req_valid   = 1'b0;
        req_data    = 8'h00;
        req_capture = 1'b0;
        rsp_ready   = 1'b0;
        func_d      = 8'h00;
        pre_val     = 8'h00;
        pre_en      = 1'b0;
        test_reset();
        test_shift();
        test_capture();
        test_backpressure();
        test_reset_mid_shift();
`ifdef SCAN_CHAIN_CTRL_PARITY_EN
        test_parity();
`endif
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/scan_chain_ctrl.md
Name: scan_chain_ctrl

Overview:
- Upstream controller for a chain of scan flops that have a hold-enable (disable) input and LED indicators.
- Accepts a parallel word over valid/ready, serially shifts it into the chain MSB first, and drives the shared scan-enable and disable lines.
- Returns the chain's previous contents as a parallel word over valid/ready.
- Optionally performs one functional capture cycle before shifting. Sits between the register-access host and the LED flop chain.

Parameters:
- ChainLen, 8, number of flops in the chain (>= 2).
- CntWidth, $clog2(ChainLen+1), shift counter width (derived; not overridden).

Ports:
- clk_i  input  1  clock, rising edge; also clocks the chain.
- rst_ni  input  1  asynchronous active-low reset.
- req_valid_i  input  1  request valid.
- req_ready_o  output  1  request ready.
- req_data_i  input  ChainLen  word to load; bit i lands in chain flop i.
- req_capture_i  input  1  perform one functional capture before shifting.
- rsp_valid_o  output  1  response valid.
- rsp_ready_i  input  1  response ready.
- rsp_data_o  output  ChainLen  chain contents before the shift; bit i from flop i.
- scan_en_o  output  1  to every flop's scan_en_i.
- scan_d_o  output  1  to flop 0's scan_d_i.
- scan_q_i  input  1  from flop ChainLen-1's q_o.
- dis_o  output  1  to every flop's dis_i; high holds the flop.
- busy_o  output  1  high in every state except IDLE.

Behaviour:
- Reset values: state IDLE; req_ready_o=1, rsp_valid_o=0, rsp_data_o=0, scan_en_o=0, scan_d_o=0, dis_o=1, busy_o=0. All outputs are registered or decoded from state only.
- State IDLE:
  - req_ready_o=1, dis_o=1, scan_en_o=0.
  - On req_valid_i && req_ready_o: latch req_data_i into tx and req_capture_i into a flag, clear counter.
  - Next state: CAPTURE if the flag is set, otherwise SHIFT.
- State CAPTURE (exactly 1 cycle): dis_o=0, scan_en_o=0. The chain loads its functional d inputs at the ending edge. Next state: SHIFT.
- State SHIFT (exactly ChainLen cycles): scan_en_o=1, dis_o=1, scan_d_o=tx[ChainLen-1]. At each edge:
  - tx shifts left, zero fill.
  - rx={rx[ChainLen-2:0], scan_q_i}.
  - counter increments.
  - At the edge where the counter reaches ChainLen-1, move to DONE.
- State DONE:
  - rsp_valid_o=1 and rsp_data_o=rx, both held stable until rsp_ready_i.
  - req_ready_o=0, scan_en_o=0, dis_o=1.
  - On handshake, go to IDLE. No back-to-back request acceptance in DONE.
- Latency:
  - Request accepted at edge t; scan_en_o high during cycles t+1..t+ChainLen.
  - rsp_valid_o from cycle t+ChainLen+1.
  - Add 1 cycle when capture is used.
- req_valid_i outside IDLE is ignored; req_data_i is not sampled.
- After a completed transaction the chain holds req_data_i; every flop's dis_o is high, so the chain holds until the next transaction.
- Asynchronous reset mid-operation:
  - Immediate return to reset values; the transaction is dropped and no response is issued.
  - Chain contents are partial; the flops have their own reset.
- Counter and rx arithmetic are unsigned. rx is cleared on each accept.

Optional Feature:
- Macro: SCAN_CHAIN_CTRL_PARITY_EN.
- Defined: adds output rsp_parity_o (1 bit) = XOR-reduce of rx. It is registered on entry to DONE, stable with rsp_data_o, and reset to 0.
- Undefined: port and logic absent; behaviour otherwise identical.

Decomposition:
- Package scan_chain_ctrl_pkg:
  - state_e typedef (IDLE, CAPTURE, SHIFT, DONE), 2-bit encoding.
  - localparam DefaultChainLen = 8.
- Sub-module scan_shift_reg (tx/rx shift registers plus counter, with load/shift/clear controls and a last-bit flag). The FSM stays in scan_chain_ctrl.

Test Plan (ChainLen=8; bench models 8 sdffr_dis_led-equivalent flops):
1. Assert rst_ni=0 mid-idle -> req_ready_o=1, scan_en_o=0, dis_o=1, rsp_valid_o=0, busy_o=0 with no clock edge needed.
2. Chain preloaded 0x3C; request 0xA5, no capture:
   - scan_en_o high exactly 8 cycles.
   - Chain=0xA5; rsp_data_o=0x3C at cycle t+9.
3. Chain functional inputs 0x5A; request 0x00 with capture:
   - dis_o low exactly 1 cycle, then 8 shifts.
   - rsp_data_o=0x5A; chain=0x00.
4. Response backpressure: rsp_ready_i low 5 cycles with req_valid_i high:
   - rsp_valid_o/rsp_data_o stable; req_ready_o=0; scan_en_o=0; dis_o=1; chain unchanged.
   - After handshake, the next request is accepted in IDLE.
5. Reset asserted after 3 shift edges -> scan_en_o falls asynchronously; state IDLE; no rsp_valid_o; next request completes normally.
6. With SCAN_CHAIN_CTRL_PARITY_EN: chain 0xA5 -> rsp_parity_o=0; chain 0x01 -> rsp_parity_o=1.
